// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN accelerator result-check blocks.
// Holds the checker FSM state encoding, the BRAM port geometry and the class counts
// of the two classifier networks.
`timescale 1ns/1ps
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam int BRAM_ADDR_W        = 32;
    localparam int BRAM_DATA_W        = 32;
    localparam int BRAM_WE_W          = 4;
    localparam int WORD_BYTES         = 4;
    localparam int NUM_CLASSES_NUMBER = 10;
    localparam int NUM_CLASSES_LETTER = 27;

    // Byte address of the following 32-bit word.
    function automatic logic [BRAM_ADDR_W-1:0] next_word_addr(input logic [BRAM_ADDR_W-1:0] addr);
        return addr + BRAM_ADDR_W'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/result_checker_if.sv
// result_checker_if: one standard 32-bit BRAM port.
//   addr : byte address
//   en   : port enable
//   we   : byte write enables
//   dout : read data, one cycle after addr/en
// master = the block driving the port, slave = the memory.
`timescale 1ns/1ps
interface result_checker_if;
    import cnn_pkg::*;

    logic [BRAM_ADDR_W-1:0] addr;
    logic                   en;
    logic [BRAM_WE_W-1:0]   we;
    logic [BRAM_DATA_W-1:0] dout;

    modport master (output addr, output en, output we, input dout);
    modport slave  (input addr, input en, input we, output dout);
endinterface

// File: rtl/result_checker_argmax_tracker.sv
// argmax_tracker: running signed maximum of a stream of (idx, value) samples.
// Only a strictly greater value replaces the held maximum, so on a tie the
// lower index wins.
//   clear_i       : restart from the most negative value, index 0
//   valid_i       : idx_i/val_i carry a sample this cycle
//   idx_i, val_i  : sample index and signed value
//   best_idx_nx_o : index of the maximum including this cycle's sample
`timescale 1ns/1ps
module argmax_tracker #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] val_i,
    output logic [IDX_W-1:0]  best_idx_nx_o
);

    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;

    // Next maximum: clear wins, else take the sample only when strictly greater.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (clear_i) begin
            best_val_d = MOST_NEG;
            best_idx_d = {IDX_W{1'b0}};
        end else if (valid_i && ($signed(val_i) > best_val_q)) begin
            best_val_d = $signed(val_i);
            best_idx_d = idx_i;
        end else begin
            best_val_d = best_val_q;
            best_idx_d = best_idx_q;
        end
    end

    // Maximum registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_val_q <= MOST_NEG;
            best_idx_q <= {IDX_W{1'b0}};
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_idx_nx_o = best_idx_d;

endmodule

// File: rtl/result_checker.sv
// result_checker: walks N classifier scores and N golden words over two BRAM ports,
// counts mismatches, records the first mismatching index and finds the argmax class.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : begin a check (ignored unless idle)
//   mode_i         : 1 -> NUM_A classes, 0 -> NUM_B classes (sampled at start)
//   res_bus        : result BRAM port (read only)
//   gld_bus        : golden BRAM port (read only)
//   busy_o         : check in progress
//   done_o         : one-cycle pulse, results valid
//   pass_o         : no mismatches in the last check
//   err_cnt_o      : mismatch count
//   first_err_o    : lowest mismatching index (0 if none)
//   result_o       : argmax index of the signed scores
// Reads are pipelined: one word pair per ISSUE cycle, compared one cycle later
// when the BRAM data returns; DRAIN consumes the final word, FIN reports.
`timescale 1ns/1ps
module result_checker
    import cnn_pkg::*;
#(
    parameter int                     DATA_W   = 32,
    parameter int                     NUM_A    = NUM_CLASSES_NUMBER,
    parameter int                     NUM_B    = NUM_CLASSES_LETTER,
    parameter int                     MAX_N    = 32,
    parameter logic [BRAM_ADDR_W-1:0] BASE_RES = 32'h0000_0000,
    parameter logic [BRAM_ADDR_W-1:0] BASE_GLD = 32'h0000_0000,
    parameter int                     IDX_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                mode_i,
    result_checker_if.master    res_bus,
    result_checker_if.master    gld_bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [IDX_W:0]      err_cnt_o,
    output logic [IDX_W-1:0]    first_err_o,
    output logic [IDX_W-1:0]    result_o
);

    state_e                 state_q, state_d;
    logic [IDX_W:0]         n_q, n_d;
    logic [IDX_W-1:0]       k_q, k_d;
    logic [BRAM_ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [BRAM_ADDR_W-1:0] gld_addr_q, gld_addr_d;
    logic                   en_q, en_d;
    logic                   valid_q, valid_d;
    logic [IDX_W-1:0]       pidx_q, pidx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [IDX_W:0]         err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]       first_err_q, first_err_d;
    logic [IDX_W-1:0]       result_q, result_d;
    logic                   clear_s;
    logic                   mismatch_s;
    logic                   last_s;
    logic [IDX_W-1:0]       best_idx_nx_s;

    assign mismatch_s = (res_bus.dout[DATA_W-1:0] != gld_bus.dout[DATA_W-1:0]);
    assign last_s     = (({1'b0, k_q} + (IDX_W+1)'(1)) == n_q);

    argmax_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear_s),
        .valid_i       (valid_q),
        .idx_i         (pidx_q),
        .val_i         (res_bus.dout[DATA_W-1:0]),
        .best_idx_nx_o (best_idx_nx_s)
    );

    // Compare stage plus FSM next-state and issue/report logic.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        res_addr_d  = res_addr_q;
        gld_addr_d  = gld_addr_q;
        en_d        = en_q;
        valid_d     = 1'b0;
        pidx_d      = k_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        result_d    = result_q;
        clear_s     = 1'b0;

        // Data returned for the word issued last cycle.
        if (valid_q && mismatch_s) begin
            err_cnt_d = err_cnt_q + (IDX_W+1)'(1);
            if (err_cnt_q == {(IDX_W+1){1'b0}}) begin
                first_err_d = pidx_q;
            end else begin
                first_err_d = first_err_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_ISSUE;
                    n_d         = mode_i ? (IDX_W+1)'(NUM_A) : (IDX_W+1)'(NUM_B);
                    k_d         = {IDX_W{1'b0}};
                    res_addr_d  = BASE_RES;
                    gld_addr_d  = BASE_GLD;
                    en_d        = 1'b1;
                    busy_d      = 1'b1;
                    clear_s     = 1'b1;
                    err_cnt_d   = {(IDX_W+1){1'b0}};
                    first_err_d = {IDX_W{1'b0}};
                    result_d    = {IDX_W{1'b0}};
                    pass_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                valid_d = 1'b1;
                pidx_d  = k_q;
                if (last_s) begin
                    // Address is left on the final word while EN is low.
                    state_d = ST_DRAIN;
                    en_d    = 1'b0;
                end else begin
                    k_d        = k_q + IDX_W'(1);
                    res_addr_d = next_word_addr(res_addr_q);
                    gld_addr_d = next_word_addr(gld_addr_q);
                end
            end
            ST_DRAIN: begin
                // Last word compares this cycle; report from the next-state values.
                state_d  = ST_FIN;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = best_idx_nx_s;
                pass_d   = (err_cnt_d == {(IDX_W+1){1'b0}});
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= {(IDX_W+1){1'b0}};
            k_q         <= {IDX_W{1'b0}};
            res_addr_q  <= {BRAM_ADDR_W{1'b0}};
            gld_addr_q  <= {BRAM_ADDR_W{1'b0}};
            en_q        <= 1'b0;
            valid_q     <= 1'b0;
            pidx_q      <= {IDX_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= {(IDX_W+1){1'b0}};
            first_err_q <= {IDX_W{1'b0}};
            result_q    <= {IDX_W{1'b0}};
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            res_addr_q  <= res_addr_d;
            gld_addr_q  <= gld_addr_d;
            en_q        <= en_d;
            valid_q     <= valid_d;
            pidx_q      <= pidx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            result_q    <= result_d;
        end
    end

    assign res_bus.addr = res_addr_q;
    assign res_bus.en   = en_q;
    assign res_bus.we   = {BRAM_WE_W{1'b0}};
    assign gld_bus.addr = gld_addr_q;
    assign gld_bus.en   = en_q;
    assign gld_bus.we   = {BRAM_WE_W{1'b0}};

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_cnt_q;
    assign first_err_o = first_err_q;
    assign result_o    = result_q;

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Sequential self-check engine for the CNN accelerator's final classifier scores.
- On `start`, walks N score words from a result BRAM and N golden words from a golden BRAM, both over the standard 32-bit BRAM port interface.
- Counts mismatches, records the first mismatching index, and computes the argmax class.
- Replaces the hard-coded 10/27-entry bench compare loop with a reusable, mode-driven, parametrised block usable in simulation and on-FPGA debug.

Parameters:
- DATA_W, 32, width of score and golden words (signed two's complement)
- NUM_A, 10, class count when mode=1 (number network)
- NUM_B, 27, class count when mode=0 (letter network)
- MAX_N, 32, upper bound on class count; sets index/counter widths
- BASE_RES, 0, byte base address of scores in result BRAM
- BASE_GLD, 0, byte base address of golden words in golden BRAM
- IDX_W, 8, width of the result/index outputs; must satisfy 2^IDX_W >= MAX_N

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse begins a check; ignored while busy
- mode  in  1  1: N=NUM_A, 0: N=NUM_B; sampled only on accepted start
- RES_ADDR  out  32  result BRAM byte address
- RES_EN  out  1  result BRAM enable
- RES_WE  out  4  result BRAM write enable; tied 4'b0
- RES_DOUT  in  32  result BRAM read data, 1-cycle latency
- GLD_ADDR  out  32  golden BRAM byte address
- GLD_EN  out  1  golden BRAM enable
- GLD_WE  out  4  golden BRAM write enable; tied 4'b0
- GLD_DOUT  in  32  golden BRAM read data, 1-cycle latency
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when results are valid
- pass  out  1  err_cnt==0; valid from done until next start
- err_cnt  out  IDX_W+1  number of mismatching entries
- first_err  out  IDX_W  index of the lowest mismatching entry; 0 if none
- result  out  IDX_W  argmax index of the signed scores

Behaviour:
- Reset values: all outputs 0 (EN, WE, ADDR, busy, done, pass, err_cnt, first_err, result); state IDLE.
- Reset mid-operation aborts the walk immediately; no done pulse is produced.
- IDLE:
  - On start, latch N from mode, clear counters, set best_val to the most negative value and best_idx=0.
  - Go to ISSUE.
- ISSUE: pipelined read stream.
  - Cycle k (k=0..N-1): EN=1, RES_ADDR=BASE_RES+4k, GLD_ADDR=BASE_GLD+4k.
  - A valid_d flag and idx_d register delay k by one cycle to align with DOUT.
- Compare stage, for each aligned k (one cycle after issue):
  - Mismatch = RES_DOUT != GLD_DOUT, bitwise over DATA_W.
  - On mismatch, err_cnt++. If this is the first mismatch, first_err=k.
  - If $signed(RES_DOUT) > best_val, update best_val and best_idx=k. Strict greater-than means a tie keeps the lower index.
- After the last issue (k=N-1): EN drops to 0 and the FSM goes to DRAIN. DRAIN lasts one cycle and processes entry N-1.
- FIN, one cycle:
  - Latch result=best_idx and pass=(err_cnt==0).
  - Pulse done=1, drop busy, return to IDLE.
- Latency: start accepted at cycle 0; done asserts at cycle N+2. For N=10, done is at cycle 12.
- ADDR holds its last value when EN=0.
- Outputs result, pass, err_cnt and first_err hold until the next accepted start. They are cleared at that start.
- A start coincident with done (FIN) is ignored; a start on the cycle after done is accepted.
- A mode change while busy has no effect.
- N=1 is legal: one issue cycle, then DRAIN, then FIN.
- err_cnt cannot overflow, since its width is IDX_W+1 and N <= MAX_N.

Decomposition:
- Shared package cnn_pkg holds:
  - state encoding (IDLE, ISSUE, DRAIN, FIN)
  - BRAM_ADDR_W=32, BRAM_WE_W=4, WORD_BYTES=4
  - NUM_CLASSES_NUMBER=10, NUM_CLASSES_LETTER=27
- One natural sub-module: argmax_tracker. It takes valid, idx and signed value, and owns the running maximum and tie rule. Clear is driven on start.
- Address generation and the compare/count logic stay in the top level.

Test Plan:
- mode=1, golden equal to scores, scores[7]=0x0000_0100 and all others smaller -> done at cycle 12, pass=1, err_cnt=0, result=7.
- mode=0, scores[3]!=golden[3] and scores[20]!=golden[20] -> done at cycle 29, err_cnt=2, first_err=3, pass=0.
- Tie and sign check: all scores negative, with scores[2]=scores[5]=0xFFFF_FFF0 as the maximum -> result=2.
- rst pulsed at cycle 5 of a mode=1 run -> all outputs 0 next cycle, no done pulse. A fresh start afterwards completes normally.
- start re-pulsed while busy, and mode toggled mid-run -> original N is kept, one done pulse. RES_ADDR sequence is BASE_RES+0,4,...,36 with EN high exactly 10 cycles.
- Parameter override NUM_A=1, BASE_RES=0x40 -> single read at 0x40, done at cycle 3, result=0.
